// File: rtl/dm_pkg.sv
// Shared definitions for the dm_bank data memory.
//   - access size encodings carried on req_size
//   - FSM state type used by dm_bank
//   - lane_mask(): which byte lanes of a word an access touches
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_t;

    // Lane i holds bits [8*i+7:8*i] of the word (little-endian lanes).
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lane;
            SZ_HALF: lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational byte-lane formatter for dm_bank.
//   old_word : current contents of the addressed word
//   wdata    : right-justified store data
//   size     : SZ_BYTE / SZ_HALF / SZ_WORD (SZ_BAD leaves the word untouched)
//   lane     : byte address bits [1:0]
//   sign_ext : sign-extend sub-word loads
//   merged   : old_word with the selected lanes replaced by store data
//   load_val : selected byte/half right-justified and extended, or whole word
module dm_lane_fmt
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] merged,
    output logic [31:0] load_val
);

    logic [3:0]  mask;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    always_comb begin
        mask   = lane_mask(size, lane);
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                // A half stores its low byte in the even lane of the pair.
                if (size == SZ_BYTE)      merged[8*i +: 8] = wdata[7:0];
                else if (size == SZ_HALF) merged[8*i +: 8] = wdata[8*(i%2) +: 8];
                else                      merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        sel_b = old_word[8*lane +: 8];
        sel_h = lane[1] ? old_word[31:16] : old_word[15:0];
        case (size)
            SZ_BYTE: load_val = {{24{sign_ext & sel_b[7]}}, sel_b};
            SZ_HALF: load_val = {{16{sign_ext & sel_h[15]}}, sel_h};
            default: load_val = old_word;
        endcase
    end

endmodule

// File: rtl/dm_bank.sv
// Parametrised MIPS data memory with byte/half/word access, exceptions,
// configurable wait states and a sequential clear after reset.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake, accepted when both high
//   req_we/size/signed  : store flag, access size, sign-extend loads
//   req_addr/wdata/pc   : byte address, right-justified store data, PC (trace)
//   resp_valid          : one-cycle completion pulse
//   resp_rdata/resp_exc : extended load data (0 for stores/faults), fault flag
//   busy                : high whenever not IDLE (stalls the MEM stage)
module dm_bank
    import dm_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter int          WAIT_CYC  = 0,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_exc,
    output logic        busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] clr_idx;
    logic [3:0]        cnt;
    logic              r_we, r_signed;
    logic [1:0]        r_size;
    logic [31:0]       r_addr, r_wdata, r_pc;
    logic [31:0]       mem [DEPTH];

    logic              accept, commit;
    logic              c_we, c_signed, c_exc;
    logic [1:0]        c_size;
    logic [31:0]       c_addr, c_wdata, c_pc, c_off;
    logic [ADDR_W-1:0] c_idx;
    logic [31:0]       merged, load_val;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_idx;
    logic [31:0]       mem_wd;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    // With no wait states the accept edge is also the commit edge.
    assign commit    = (accept && WAIT_CYC == 0) || (state == WAIT && cnt == 4'd0);

    // Commit operand source: live inputs when committing on the accept edge,
    // otherwise the request captured at accept.
    always_comb begin
        if (state == IDLE) begin
            c_we = req_we;  c_size = req_size;  c_signed = req_signed;
            c_addr = req_addr;  c_wdata = req_wdata;  c_pc = req_pc;
        end else begin
            c_we = r_we;  c_size = r_size;  c_signed = r_signed;
            c_addr = r_addr;  c_wdata = r_wdata;  c_pc = r_pc;
        end
        c_off = c_addr - BASE_ADDR;
        c_idx = c_off[ADDR_W+1:2];
        c_exc = (c_size == SZ_BAD)
             || (c_size == SZ_HALF && c_addr[0])
             || (c_size == SZ_WORD && c_addr[1:0] != 2'b00)
             || ((c_off >> (ADDR_W + 2)) != 32'd0);
    end

    dm_lane_fmt u_fmt (
        .old_word (mem[c_idx]),
        .wdata    (c_wdata),
        .size     (c_size),
        .lane     (c_addr[1:0]),
        .sign_ext (c_signed),
        .merged   (merged),
        .load_val (load_val)
    );

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR:   if (&clr_idx) state_nx = IDLE;
            IDLE:    if (accept) state_nx = (WAIT_CYC > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = CLEAR;
        endcase
    end

    // Single write port shared by the clear sweep and store commits.
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = c_idx;
        mem_wd  = merged;
        if (!reset) begin
            if (state == CLEAR) begin
                mem_we  = 1'b1;
                mem_idx = clr_idx;
                mem_wd  = '0;
            end else if (commit && c_we && !c_exc) begin
                mem_we  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk)
        if (mem_we) mem[mem_idx] <= mem_wd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_exc   <= 1'b0;
            r_we       <= 1'b0;
            r_size     <= SZ_BYTE;
            r_signed   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
        end else begin
            state      <= state_nx;
            resp_valid <= commit;
            if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
            if (accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_pc     <= req_pc;
                cnt      <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_exc   <= c_exc;
                resp_rdata <= (c_we || c_exc) ? 32'd0 : load_val;
            end
        end
    end

`ifndef SYNTHESIS
    // Store trace: time, pc, word-aligned byte address, merged word.
    always_ff @(posedge clk)
        if (!reset && commit && c_we && !c_exc)
            $write("%d@%h: *%h <= %h\n", $time, c_pc, {c_addr[31:2], 2'b00}, merged);
`endif

endmodule

// File: tb/tb_dm_bank.sv
module tb_dm_bank;

    localparam int          AW = 4;
    localparam int          NW = 1 << AW;
    localparam int          NB = 4 * NW;
    localparam int          W0 = 0;
    localparam int          W1 = 3;
    localparam logic [31:0] B0 = 32'h0040_0100;
    localparam logic [31:0] B1 = 32'h0000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       reset = 2'b11, req_valid = 2'b00, req_we = 2'b00, req_signed = 2'b00;
    logic [1:0]       req_ready, resp_valid, resp_exc, busy;
    logic [1:0][1:0]  req_size = '0;
    logic [1:0][31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
    logic [1:0][31:0] resp_rdata;

    dm_bank #(.ADDR_W(AW), .WAIT_CYC(W0), .BASE_ADDR(B0)) u_w0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_pc(req_pc[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_exc(resp_exc[0]),
        .busy(busy[0]));

    dm_bank #(.ADDR_W(AW), .WAIT_CYC(W1), .BASE_ADDR(B1)) u_w3 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_pc(req_pc[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_exc(resp_exc[1]),
        .busy(busy[1]));

    exp_t       q0[$], q1[$];
    logic [7:0] mm0 [NB];
    logic [7:0] mm1 [NB];
    int         checks = 0, failures = 0;

    function automatic int wc(input int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] base(input int i);
        return (i == 0) ? B0 : B1;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    function automatic void expired(input string name, input int i);
        checks++;
        failures++;
        $display("FAIL %s[%0d]: wait bound expired at cycle %0d", name, i, cyc);
    endfunction

    // Byte-addressed reference memory; words are little-endian byte groups.
    task automatic model(input int i, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
        logic [31:0] off, v;
        logic [7:0]  b;
        int          nb;
        off = addr - base(i);
        nb  = 1 << size;
        v   = '0;
        e.rdata = '0;
        e.exc   = 1'b0;
        e.cyc   = 0;
        if (size == 2'd3 || (size == 2'd1 && addr[0]) ||
            (size == 2'd2 && addr[1:0] != 2'b00) || off >= 32'(NB)) begin
            e.exc = 1'b1;
        end else if (we) begin
            for (int k = 0; k < nb; k++)
                if (i == 0) mm0[int'(off) + k] = wdata[8*k +: 8];
                else        mm1[int'(off) + k] = wdata[8*k +: 8];
        end else begin
            for (int k = 0; k < nb; k++) begin
                b = (i == 0) ? mm0[int'(off) + k] : mm1[int'(off) + k];
                v = v | ({24'd0, b} << (8*k));
            end
            if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
            e.rdata = v;
        end
    endtask

    // Drives one request (offset is relative to the instance base), returns accept cycle.
    task automatic issue(input int i, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] off, input logic [31:0] wdata, output int acc);
        exp_t e;
        int   n;
        model(i, we, size, sgn, off + base(i), wdata, e);
        req_valid[i]  = 1'b1;
        req_we[i]     = we;
        req_size[i]   = size;
        req_signed[i] = sgn;
        req_addr[i]   = off + base(i);
        req_wdata[i]  = wdata;
        req_pc[i]     = $urandom;
        n = 0;
        while (!req_ready[i] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready[i]) begin
            expired("accept", i);
            req_valid[i] = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        e.cyc = acc + 1 + wc(i);
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (qsize(i) != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (qsize(i) != 0) expired("drain", i);
    endtask

    task automatic pulse_reset(input int i);
        reset[i] = 1'b1;
        if (i == 0) q0.delete(); else q1.delete();
        for (int j = 0; j < NB; j++)
            if (i == 0) mm0[j] = 8'h00; else mm1[j] = 8'h00;
        @(posedge clk); #1;
        chk($sformatf("rst_ready[%0d]", i), 32'(req_ready[i]), 32'd0);
        chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd1);
        chk($sformatf("rst_resp_valid[%0d]", i), 32'(resp_valid[i]), 32'd0);
        chk($sformatf("rst_resp_rdata[%0d]", i), resp_rdata[i], 32'd0);
        chk($sformatf("rst_resp_exc[%0d]", i), 32'(resp_exc[i]), 32'd0);
        reset[i] = 1'b0;
    endtask

    task automatic wait_clear(input int i);
        int n;
        n = 0;
        while (!req_ready[i] && n < 4 * NW) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("clear_cycles[%0d]", i), 32'(n), 32'(NW));
    endtask

    task automatic run_all(input int i);
        int          a, b, sel;
        logic [1:0]  sz;
        logic [31:0] off;
        pulse_reset(i);
        wait_clear(i);
        for (int k = 0; k < 4; k++) issue(i, 1'b0, 2'd2, 1'b0, 4 * $urandom_range(0, NW - 1), 32'd0, a);
        // word store / load / byte merge
        issue(i, 1'b1, 2'd2, 1'b0, 32'h8, 32'h8899AABB, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, a);
        issue(i, 1'b1, 2'd0, 1'b0, 32'h9, 32'hABCDEF7F, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, a);
        // extension
        issue(i, 1'b1, 2'd2, 1'b0, 32'h0, 32'h8000FF80, a);
        issue(i, 1'b0, 2'd0, 1'b1, 32'h0, 32'd0, a);
        issue(i, 1'b0, 2'd0, 1'b0, 32'h0, 32'd0, a);
        issue(i, 1'b0, 2'd1, 1'b1, 32'h2, 32'd0, a);
        issue(i, 1'b0, 2'd1, 1'b0, 32'h2, 32'd0, a);
        // exceptions, then readback of the targeted words
        issue(i, 1'b1, 2'd1, 1'b0, 32'h3, 32'h1234, a);
        issue(i, 1'b1, 2'd2, 1'b0, 32'h6, 32'hDEADBEEF, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h6, 32'd0, a);
        issue(i, 1'b1, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, a);
        issue(i, 1'b0, 2'd3, 1'b0, 32'h0, 32'd0, a);
        issue(i, 1'b1, 2'd2, 1'b0, 32'(NB), 32'h55555555, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'(NB), 32'd0, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'd0, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h0, 32'd0, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h4, 32'd0, a);
        // back-to-back: second request held valid from the cycle after the first accept
        issue(i, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, a);
        issue(i, 1'b0, 2'd2, 1'b0, 32'hC, 32'd0, b);
        chk($sformatf("b2b_accept_gap[%0d]", i), 32'(b - a), 32'(2 + wc(i)));
        drain(i);
        // reset one cycle after a store accept drops the store
        if (wc(i) > 0) begin
            issue(i, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, a);
            pulse_reset(i);
            wait_clear(i);
            issue(i, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0, a);
            drain(i);
        end
        // reset halfway through the clear sweep restarts the count
        pulse_reset(i);
        repeat (NW / 2) begin @(posedge clk); #1; end
        pulse_reset(i);
        wait_clear(i);
        issue(i, 1'b0, 2'd2, 1'b0, 32'h8, 32'd0, a);
        // randomized traffic against the model
        for (int k = 0; k < 200; k++) begin
            sz  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 99);
            if (sel < 60)      off = $urandom_range(0, NB - 1);
            else if (sel < 85) off = ($urandom_range(0, NB - 1) >> sz) << sz;
            else if (sel < 95) off = 32'(NB) + $urandom_range(0, 63);
            else               off = 32'hFFFFFFFF - $urandom_range(0, 7);
            issue(i, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), off, $urandom, a);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        drain(i);
    endtask

    // Response monitor: every resp_valid must match the oldest outstanding expectation.
    task automatic mon(input int i);
        exp_t e;
        if (qsize(i) == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected[%0d]: got rdata=%h exc=%b at cycle %0d, expected none",
                     i, resp_rdata[i], resp_exc[i], cyc);
            return;
        end
        if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk($sformatf("resp_rdata[%0d]", i), resp_rdata[i], e.rdata);
        chk($sformatf("resp_exc[%0d]", i), 32'(resp_exc[i]), 32'(e.exc));
        chk($sformatf("resp_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (resp_valid[i] === 1'b1) mon(i);
            if (req_ready[i] === 1'b1) chk($sformatf("busy_in_idle[%0d]", i), 32'(busy[i]), 32'd0);
        end
    end

    initial begin
        fork
            run_all(0);
            run_all(1);
        join
        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
